// File: rtl/fpu_lead0_pkg.sv
// ============================================================================
// Module   : fpu_lead0_pkg
// Purpose  : Shared sizing helpers and types for the leading-digit counter
//            and normaliser pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_lead0_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_CNTW  = 7;

    // Node count inside the counter tree; wide enough for a 64-bit all-zero run.
    typedef logic [MAX_CNTW-1:0] lead_cnt_t;

    function automatic int grp_count(input int width);
        return (width + 3) / 4;
    endfunction

    function automatic int zero_cnt(input int width);
        return width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_lead0_tree.sv
// ============================================================================
// Module   : fpu_lead0_tree
// Purpose  : Combinational leading-zero counter built from 4-bit groups that
//            are merged pairwise, MSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_lead0_tree
    import fpu_lead0_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int CNTW  = 6
) (
    input  logic [WIDTH-1:0] d,
    output logic [CNTW-1:0]  cnt,
    output logic             zero
);

    localparam int NG       = grp_count(WIDTH);
    localparam int NGP      = 1 << $clog2(NG);
    localparam int PW       = 4 * NG;
    localparam int ZERO_CNT = zero_cnt(WIDTH);

    logic [PW-1:0] w_pad;
    // Heap-indexed tree: node 1 is the root, leaves occupy NGP..2*NGP-1.
    lead_cnt_t     w_cnt [1:2*NGP-1];

    // Padding ones at the LSB end stop an all-zero input at exactly WIDTH.
    generate
        if (PW == WIDTH) begin : g_nopad
            assign w_pad = d;
        end else begin : g_pad
            assign w_pad = {d, {(PW-WIDTH){1'b1}}};
        end
    endgenerate

    generate
        for (genvar g = 0; g < NGP; g++) begin : g_leaf
            if (g < NG) begin : g_real
                logic [3:0] w_nib;
                assign w_nib = w_pad[PW-1-4*g -: 4];
                assign w_cnt[NGP+g] = lead_cnt_t'(w_nib[3] ? 3'd0 :
                                                  w_nib[2] ? 3'd1 :
                                                  w_nib[1] ? 3'd2 :
                                                  w_nib[0] ? 3'd3 : 3'd4);
            end else begin : g_fill
                assign w_cnt[NGP+g] = lead_cnt_t'(4);
            end
        end

        // A child whose count equals its own size is all zero, so the right
        // child's count continues the run.
        for (genvar i = 1; i < NGP; i++) begin : g_node
            localparam lead_cnt_t HALF = lead_cnt_t'((4 * NGP) >> $clog2(i + 1));
            assign w_cnt[i] = (w_cnt[2*i] == HALF) ? HALF + w_cnt[2*i+1]
                                                   : w_cnt[2*i];
        end
    endgenerate

    assign zero = (w_cnt[1] >= lead_cnt_t'(WIDTH));
    assign cnt  = zero ? CNTW'(ZERO_CNT) : CNTW'(w_cnt[1]);

endmodule

`default_nettype wire

// File: rtl/fpu_lead0_norm_pipe.sv
// ============================================================================
// Module   : fpu_lead0_norm_pipe
// Purpose  : Two-stage leading-zero/one counter and left-shift normaliser with
//            valid/ready flow control. in_rdy depends combinationally on out_rdy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_lead0_norm_pipe
    import fpu_lead0_pkg::*;
#(
    parameter int WIDTH = 53,
    parameter int CNTW  = 6,
    parameter int TAGW  = 4
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ones,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CNTW-1:0]  out_cnt,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAGW-1:0]  out_tag
);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH || (2 ** CNTW) <= WIDTH) begin : g_param_check
            $error("fpu_lead0_norm_pipe: WIDTH must be 2..64 and 2**CNTW > WIDTH");
        end
    endgenerate

    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_data;
    logic [CNTW-1:0]  r_s1_cnt;
    logic             r_s1_zero;
    logic [TAGW-1:0]  r_s1_tag;

    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_norm;
    logic [CNTW-1:0]  r_s2_cnt;
    logic             r_s2_zero;
    logic [TAGW-1:0]  r_s2_tag;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_d;
    logic [CNTW-1:0]  w_cnt;
    logic             w_zero;

    // Each stage advances when it is empty or the stage ahead is advancing.
    assign w_s2_adv = !r_s2_vld || out_rdy;
    assign w_s1_adv = !r_s1_vld || w_s2_adv;
    assign in_rdy   = w_s1_adv;

    // Counting ones is counting zeros of the complement.
    assign w_d = in_ones ? ~in_data : in_data;

    fpu_lead0_tree #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_tree (
        .d    (w_d),
        .cnt  (w_cnt),
        .zero (w_zero)
    );

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_cnt  <= '0;
            r_s1_zero <= 1'b0;
            r_s1_tag  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_norm <= '0;
            r_s2_cnt  <= '0;
            r_s2_zero <= 1'b0;
            r_s2_tag  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_vld <= in_vld;
                if (in_vld) begin
                    r_s1_data <= in_data;
                    r_s1_cnt  <= w_cnt;
                    r_s1_zero <= w_zero;
                    r_s1_tag  <= in_tag;
                end
            end
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    // A count of WIDTH shifts everything out, leaving zero.
                    r_s2_norm <= r_s1_data << r_s1_cnt;
                    r_s2_cnt  <= r_s1_cnt;
                    r_s2_zero <= r_s1_zero;
                    r_s2_tag  <= r_s1_tag;
                end
            end
        end
    end

    assign out_vld  = r_s2_vld;
    assign out_cnt  = r_s2_cnt;
    assign out_zero = r_s2_zero;
    assign out_norm = r_s2_norm;
    assign out_tag  = r_s2_tag;

endmodule

`default_nettype wire
